alu_seq_pg: RTL
===============

Name: alu_seq_pg

Overview:
Parametrised, power-gateable sequential ALU; next generation of the 16-bit start/busy ALU.
- Width is generic (W).
- Single-cycle logic ops; iterative shift-add multiply (full 2W product); restoring divide (quotient and remainder).
- Valid/ready on both input and output, so the block can stall back-pressured consumers.
- Sits in the power-gated compute island. Power-domain controller drives pwr_en/iso_en.

Parameters:
W, 16, operand/result width (>=4, power of two)
SHW, $clog2(W), shift-amount width (derived; do not override)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
pwr_en  in  1  domain power enable; low = domain off
iso_en  in  1  isolation enable; high = clamp all outputs to 0
in_valid  in  1  request valid
in_ready  out  1  block can accept request
op_a  in  W  operand A
op_b  in  W  operand B
opcode  in  4  operation select
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
result  out  W  low result / quotient
result_hi  out  W  product high half / remainder; 0 for single-cycle ops
flag_zero  out  1  result==0
flag_carry  out  1  ADD carry-out / SUB borrow; 0 otherwise
flag_div0  out  1  DIV with op_b==0

Behaviour:
- Reset: state IDLE, cycle counter 0.
  - out_valid, result, result_hi and all flags are 0.
  - in_ready=0 during reset; it is 1 in IDLE when pwr_en=1 and iso_en=0.
- Accept: request is taken on a clk edge with in_valid & in_ready. op_a, op_b and opcode are latched; inputs may change afterwards.
- in_ready = (state==IDLE) & pwr_en & ~iso_en. It is 0 while computing and while out_valid is held.
- Opcodes:
  - 0000 ADD: result=A+B mod 2^W, carry = bit W.
  - 0001 SUB: result=A-B, carry = borrow (A<B).
  - 0010 AND; 0011 OR; 0100 XOR; 0101 NOR; 0111 XNOR.
  - 0110 SLL by B[SHW-1:0].
  - 1010 SRL by B[SHW-1:0]; 1011 SRA by B[SHW-1:0].
  - 1000 MUL: unsigned, {result_hi,result}=A*B.
  - 1001 DIV: unsigned, result=A/B, result_hi=A%B.
  - 1100-1111 are reserved: result=0, result_hi=0, completes like a single-cycle op.
- States:
  - IDLE -> EXEC1 (single-cycle ops), MUL, or DIV on accept.
  - EXEC1 -> DONE after 1 cycle.
  - MUL and DIV each iterate exactly W cycles (counter 0..W-1, one bit per cycle), then go to DONE.
  - DIV with B==0 skips iteration and goes to DONE after 1 cycle with result={W{1}}, result_hi=A, flag_div0=1.
- Latency (accept edge to out_valid high):
  - single-cycle ops: 2 cycles.
  - MUL and DIV: W+1 cycles.
  - DIV by zero: 2 cycles.
- DONE: out_valid=1, and result/flags stay stable until out_ready=1 at a clk edge; then -> IDLE.
  - Output registers keep their last value after the handshake; only out_valid drops.
  - No back-to-back accept in the same cycle as the out handshake. in_ready rises the following cycle.
- flag_zero is computed from result only (low W bits), for every op.
- pwr_en=0, sampled synchronously:
  - aborts any operation; state goes to IDLE and the counter clears.
  - out_valid, result, result_hi and flags clear to 0; a pending result is lost.
- iso_en=1 (combinational clamp):
  - in_ready, out_valid, result, result_hi and all flags read 0.
  - internal state is unaffected; computation continues if pwr_en=1.
  - When iso_en drops, the true outputs reappear.
- in_valid while not ready: ignored, no side effect.
- Async reset mid-operation: immediate return to the reset values.

Decomposition:
- Package alu_seq_pkg holds:
  - opcode localparams (OP_ADD..OP_SRA, OP_MUL, OP_DIV);
  - state enum (IDLE, EXEC1, MUL, DIV, DONE);
  - a helper function for the single-cycle op result.
- Sub-module alu_seq_muldiv: the iterative shift-add/restoring datapath.
  - Interface: start, is_div, a, b -> done, lo, hi.
  - The top level owns the handshake, power and isolation logic, and the output registers.

Test Plan:
- W=16, ADD 0xFFFF+0x0001, out_ready=1 -> out_valid 2 cycles after accept; result=0x0000, flag_carry=1, flag_zero=1.
- MUL 0x1234*0x5678 -> out_valid 17 cycles after accept; result=0x0060, result_hi=0x0626 (0x06260060); in_ready=0 throughout.
- DIV 1000/7 -> result=142, result_hi=6, latency 17. DIV 0x00AB/0 -> result=0xFFFF, result_hi=0x00AB, flag_div0=1, latency 2.
- Back-pressure: SRA 0x8000 by 3 with out_ready=0 for 5 cycles -> result 0xF000 held stable, in_ready=0; handshake releases it, in_ready=1 next cycle.
- MUL started, pwr_en dropped at iteration 6 -> next cycle state IDLE, out_valid=0, result=0; new ADD 2+3 after pwr_en=1 returns 5.
- iso_en=1 during DIV 1000/7 -> all outputs read 0; iso_en released after completion -> out_valid=1, result=142; rst_n pulsed mid-DIV -> all outputs 0 at once.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared opcodes, FSM state encoding and the single-cycle operation helper
// for the power-gateable sequential ALU.
package alu_seq_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_NOR  = 4'b0101;
  localparam logic [3:0] OP_SLL  = 4'b0110;
  localparam logic [3:0] OP_XNOR = 4'b0111;
  localparam logic [3:0] OP_MUL  = 4'b1000;
  localparam logic [3:0] OP_DIV  = 4'b1001;
  localparam logic [3:0] OP_SRL  = 4'b1010;
  localparam logic [3:0] OP_SRA  = 4'b1011;

  // Helper works on a fixed wide datapath; callers extend operands and truncate to W.
  localparam int ALU_MAXW = 64;
  localparam int ALU_SHW  = 6;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    EXEC1 = 3'd1,
    MUL   = 3'd2,
    DIV   = 3'd3,
    DONE  = 3'd4
  } state_e;

  function automatic logic [ALU_MAXW-1:0] alu_sc_op(
    input logic [3:0]          op,
    input logic [ALU_MAXW-1:0] a,
    input logic [ALU_MAXW-1:0] b,
    input logic [ALU_SHW-1:0]  sh
  );
    logic [ALU_MAXW-1:0] r;
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NOR:  r = ~(a | b);
      OP_XNOR: r = ~(a ^ b);
      OP_SLL:  r = a << sh;
      OP_SRL:  r = a >> sh;
      OP_SRA:  r = $signed(a) >>> sh;
      default: r = {ALU_MAXW{1'b0}};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_seq_muldiv.sv
// Iterative datapath: shift-add unsigned multiply and restoring unsigned
// divide, one bit per cycle for W cycles after a start pulse.
module alu_seq_muldiv
  import alu_seq_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_start,
  input  logic         i_is_div,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic         o_done,
  output logic [W-1:0] o_lo,
  output logic [W-1:0] o_hi
);

  localparam int SHW = $clog2(W);
  localparam logic [SHW-1:0] LAST = SHW'(W - 1);

  logic           r_busy;
  logic           r_div;
  logic [SHW-1:0] r_cnt;
  logic [W-1:0]   r_hi;
  logic [W-1:0]   r_lo;
  logic [W-1:0]   r_m;

  logic [W:0]     w_sum;
  logic [W:0]     w_shift;
  logic [W:0]     w_trial;
  logic [W-1:0]   w_hi_nx;
  logic [W-1:0]   w_lo_nx;

  // MUL keeps {hi,lo} as the product shifting right; DIV keeps remainder in hi, quotient shifting into lo.
  always_comb begin
    w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_m} : {(W+1){1'b0}});
    w_shift = {r_hi, r_lo[W-1]};
    w_trial = w_shift - {1'b0, r_m};
    w_hi_nx = r_hi;
    w_lo_nx = r_lo;
    if (r_div) begin
      if (!w_trial[W]) begin
        w_hi_nx = w_trial[W-1:0];
        w_lo_nx = {r_lo[W-2:0], 1'b1};
      end else begin
        w_hi_nx = w_shift[W-1:0];
        w_lo_nx = {r_lo[W-2:0], 1'b0};
      end
    end else begin
      w_hi_nx = w_sum[W:1];
      w_lo_nx = {w_sum[0], r_lo[W-1:1]};
    end
  end

  // Iteration registers and bit counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
      r_div  <= 1'b0;
      r_cnt  <= {SHW{1'b0}};
      r_hi   <= {W{1'b0}};
      r_lo   <= {W{1'b0}};
      r_m    <= {W{1'b0}};
    end else if (i_clr) begin
      r_busy <= 1'b0;
      r_div  <= 1'b0;
      r_cnt  <= {SHW{1'b0}};
      r_hi   <= {W{1'b0}};
      r_lo   <= {W{1'b0}};
      r_m    <= {W{1'b0}};
    end else if (i_start) begin
      r_busy <= 1'b1;
      r_div  <= i_is_div;
      r_cnt  <= {SHW{1'b0}};
      r_hi   <= {W{1'b0}};
      r_lo   <= i_is_div ? i_a : i_b;
      r_m    <= i_is_div ? i_b : i_a;
    end else if (r_busy) begin
      r_hi <= w_hi_nx;
      r_lo <= w_lo_nx;
      if (r_cnt == LAST) begin
        r_busy <= 1'b0;
        r_cnt  <= {SHW{1'b0}};
      end else begin
        r_cnt <= r_cnt + SHW'(1);
      end
    end else begin
      r_busy <= r_busy;
    end
  end

  assign o_done = r_busy & (r_cnt == LAST);
  assign o_lo   = r_lo;
  assign o_hi   = r_hi;

endmodule

// File: rtl/alu_seq_pg.sv
// Power-gateable sequential ALU: valid/ready handshake, FSM, registered
// results, synchronous power-off clear and combinational output isolation.
module alu_seq_pg
  import alu_seq_pkg::*;
#(
  parameter int W   = 16,
  parameter int SHW = $clog2(W)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_pwr_en,
  input  logic         i_iso_en,
  input  logic         i_in_valid,
  output logic         o_in_ready,
  input  logic [W-1:0] i_op_a,
  input  logic [W-1:0] i_op_b,
  input  logic [3:0]   i_opcode,
  output logic         o_out_valid,
  input  logic         i_out_ready,
  output logic [W-1:0] o_result,
  output logic [W-1:0] o_result_hi,
  output logic         o_flag_zero,
  output logic         o_flag_carry,
  output logic         o_flag_div0
);

  state_e r_state, w_state_nx;

  logic [W-1:0] r_a, r_b;
  logic [3:0]   r_op;
  logic         r_out_valid;
  logic [W-1:0] r_result, r_result_hi;
  logic         r_zero, r_carry, r_div0;

  logic                w_in_ready, w_accept, w_out_hs, w_start, w_done;
  logic [W-1:0]        w_md_lo, w_md_hi, w_sc;
  logic [ALU_MAXW-1:0] w_a_ext;
  logic [W-1:0]        w_res, w_res_hi;
  logic                w_carry, w_div0;

  assign w_in_ready = rst_n & (r_state == IDLE) & i_pwr_en & ~i_iso_en;
  assign w_accept   = i_in_valid & w_in_ready;
  // Consumer cannot see out_valid while isolated, so no handshake then.
  assign w_out_hs   = r_out_valid & i_out_ready & ~i_iso_en;
  assign w_start    = w_accept & ((i_opcode == OP_MUL) |
                                  ((i_opcode == OP_DIV) & (i_op_b != {W{1'b0}})));

  alu_seq_muldiv #(.W(W)) u_muldiv (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clr    (~i_pwr_en),
    .i_start  (w_start),
    .i_is_div (i_opcode == OP_DIV),
    .i_a      (i_op_a),
    .i_b      (i_op_b),
    .o_done   (w_done),
    .o_lo     (w_md_lo),
    .o_hi     (w_md_hi)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // Next-state logic; power-off forces IDLE.
  always_comb begin
    w_state_nx = r_state;
    if (!i_pwr_en) begin
      w_state_nx = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            case (i_opcode)
              OP_MUL:  w_state_nx = MUL;
              OP_DIV:  w_state_nx = DIV;
              default: w_state_nx = EXEC1;
            endcase
          end else begin
            w_state_nx = IDLE;
          end
        end
        EXEC1: w_state_nx = DONE;
        MUL: begin
          if (w_done) w_state_nx = DONE;
          else        w_state_nx = MUL;
        end
        DIV: begin
          if ((r_b == {W{1'b0}}) || w_done) w_state_nx = DONE;
          else                               w_state_nx = DIV;
        end
        DONE: begin
          if (w_out_hs) w_state_nx = IDLE;
          else          w_state_nx = DONE;
        end
        default: w_state_nx = IDLE;
      endcase
    end
  end

  // Latched request operands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a  <= {W{1'b0}};
      r_b  <= {W{1'b0}};
      r_op <= 4'b0000;
    end else if (!i_pwr_en) begin
      r_a  <= {W{1'b0}};
      r_b  <= {W{1'b0}};
      r_op <= 4'b0000;
    end else if (w_accept) begin
      r_a  <= i_op_a;
      r_b  <= i_op_b;
      r_op <= i_opcode;
    end else begin
      r_op <= r_op;
    end
  end

  // SRA needs A sign-extended into the wide helper; every other op zero-extends.
  always_comb begin
    if (r_op == OP_SRA) w_a_ext = ALU_MAXW'($signed(r_a));
    else                w_a_ext = ALU_MAXW'(r_a);
  end

  assign w_sc = W'(alu_sc_op(r_op, w_a_ext, ALU_MAXW'(r_b), ALU_SHW'(r_b[SHW-1:0])));

  // Result selection and flags for the value loaded into the output registers.
  always_comb begin
    w_res    = w_sc;
    w_res_hi = {W{1'b0}};
    w_carry  = 1'b0;
    w_div0   = 1'b0;
    case (r_op)
      OP_ADD: w_carry = (w_sc < r_a);
      OP_SUB: w_carry = (r_a < r_b);
      OP_MUL: begin
        w_res    = w_md_lo;
        w_res_hi = w_md_hi;
      end
      OP_DIV: begin
        if (r_b == {W{1'b0}}) begin
          w_res    = {W{1'b1}};
          w_res_hi = r_a;
          w_div0   = 1'b1;
        end else begin
          w_res    = w_md_lo;
          w_res_hi = w_md_hi;
        end
      end
      default: w_carry = 1'b0;
    endcase
  end

  // Output registers: loaded on the first DONE cycle, held until the handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_result    <= {W{1'b0}};
      r_result_hi <= {W{1'b0}};
      r_zero      <= 1'b0;
      r_carry     <= 1'b0;
      r_div0      <= 1'b0;
    end else if (!i_pwr_en) begin
      r_out_valid <= 1'b0;
      r_result    <= {W{1'b0}};
      r_result_hi <= {W{1'b0}};
      r_zero      <= 1'b0;
      r_carry     <= 1'b0;
      r_div0      <= 1'b0;
    end else if ((r_state == DONE) && !r_out_valid) begin
      r_out_valid <= 1'b1;
      r_result    <= w_res;
      r_result_hi <= w_res_hi;
      r_zero      <= (w_res == {W{1'b0}});
      r_carry     <= w_carry;
      r_div0      <= w_div0;
    end else if (w_out_hs) begin
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= r_out_valid;
    end
  end

  assign o_in_ready   = w_in_ready;
  assign o_out_valid  = r_out_valid & ~i_iso_en;
  assign o_result     = i_iso_en ? {W{1'b0}} : r_result;
  assign o_result_hi  = i_iso_en ? {W{1'b0}} : r_result_hi;
  assign o_flag_zero  = r_zero  & ~i_iso_en;
  assign o_flag_carry = r_carry & ~i_iso_en;
  assign o_flag_div0  = r_div0  & ~i_iso_en;

endmodule
